// File: rtl/pci_target_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : pci_target_buffer_if
// Desc   : PCI control/handshake bundle between an initiator and the target.
// Rev    : 1.0  initial release
// ============================================================================
interface pci_target_buffer_if;
  logic       frame;
  logic [3:0] cbe;
  logic       irdy;
  logic       trdy;

  modport master (output frame, output cbe, output irdy, input trdy);
  modport slave  (input frame, input cbe, input irdy, output trdy);
endinterface
`default_nettype wire

// File: rtl/pci_target_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : pci_target_buffer
// Desc   : Simplified PCI memory target with a DEPTH-word buffer on the AD bus.
// Rev    : 1.0  initial release
// ============================================================================
module pci_target_buffer #(
  parameter int DEPTH = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  pci_target_buffer_if.slave bus,
  inout  wire logic [31:0]  ad
);

  localparam int               PTR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR      = PTR_W'(DEPTH - 1);
  localparam logic [3:0]       CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0]       CMD_MEM_WRITE = 4'b0111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    TURN   = 3'd2,
    READ   = 3'd3,
    WAIT   = 3'd4,
    IGNORE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             trdy_q, trdy_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic             xfer;
  logic             ad_oe;

  assign xfer     = !bus.irdy && !trdy_q;
  assign ad_oe    = (state_q == READ) && !trdy_q;
  assign ad       = ad_oe ? mem_q[rd_ptr_q] : 'z;
  assign bus.trdy = trdy_q;

  always_comb begin
    state_d  = state_q;
    trdy_d   = trdy_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    cmd_d    = cmd_q;
    mem_d    = mem_q;

    if (state_q == IDLE) begin
      trdy_d = 1'b1;
      if (!bus.frame) begin
        addr_d = ad;
        cmd_d  = bus.cbe;
        case (bus.cbe)
          CMD_MEM_WRITE: begin
            state_d  = WRITE;
            trdy_d   = 1'b0;
            wr_ptr_d = '0;
          end
          CMD_MEM_READ: begin
            state_d  = TURN;
            rd_ptr_d = '0;
          end
          default: state_d = IGNORE;
        endcase
      end
    end else if (bus.frame && bus.irdy) begin
      // Termination wins; irdy high guarantees no transfer is lost.
      state_d = IDLE;
      trdy_d  = 1'b1;
    end else begin
      case (state_q)
        WRITE: begin
          if (xfer) begin
            mem_d[wr_ptr_q] = ad;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (wr_ptr_q == LAST_PTR) begin
              state_d = WAIT;
              trdy_d  = 1'b1;
            end
          end
        end
        TURN: begin
          state_d = READ;
          trdy_d  = 1'b0;
        end
        READ: begin
          if (xfer) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            if (rd_ptr_q == LAST_PTR) begin
              state_d = WAIT;
              trdy_d  = 1'b1;
            end
          end
        end
        WAIT: begin
          // The latched command tells us which burst we paused.
          state_d = (cmd_q == CMD_MEM_WRITE) ? WRITE : READ;
          trdy_d  = 1'b0;
        end
        IGNORE:  state_d = IGNORE;
        default: begin
          state_d = IDLE;
          trdy_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trdy_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      cmd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      trdy_q   <= trdy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      cmd_q    <= cmd_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pci_target_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_pci_target_buffer
// Desc   : Directed bench for pci_target_buffer with a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pci_target_buffer;

  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_WR = 1, M_RD = 2, M_IGN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tb_oe = 1'b0;
  logic [31:0] tb_ad = '0;
  wire  [31:0] ad;

  int checks = 0;
  int failures = 0;

  pci_target_buffer_if bus ();

  assign ad = tb_oe ? tb_ad : 'z;

  pci_target_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .ad    (ad)
  );

  always #5 clk = ~clk;

  // Model: burst mode, beat index within the buffer, pause after every DEPTH beats.
  int          m_mode = M_IDLE;
  logic        m_trdy = 1'b1;
  logic        m_turn = 1'b0;
  int          m_wp = 0;
  int          m_rp = 0;
  logic [31:0] m_mem [DEPTH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_IDLE;
      m_trdy <= 1'b1;
      m_turn <= 1'b0;
      m_wp   <= 0;
      m_rp   <= 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
    end else if (m_mode == M_IDLE) begin
      if (!bus.frame) begin
        if (bus.cbe == 4'b0111) begin
          m_mode <= M_WR;
          m_trdy <= 1'b0;
          m_wp   <= 0;
        end else if (bus.cbe == 4'b0110) begin
          m_mode <= M_RD;
          m_turn <= 1'b1;
          m_rp   <= 0;
        end else begin
          m_mode <= M_IGN;
        end
      end
    end else if (bus.frame && bus.irdy) begin
      m_mode <= M_IDLE;
      m_trdy <= 1'b1;
      m_turn <= 1'b0;
    end else if (m_mode == M_WR) begin
      if (!bus.irdy && !m_trdy) begin
        m_mem[m_wp] <= tb_ad;
        m_wp        <= (m_wp + 1) % DEPTH;
        if ((m_wp + 1) % DEPTH == 0) m_trdy <= 1'b1;
      end else if (m_trdy) begin
        m_trdy <= 1'b0;
      end
    end else if (m_mode == M_RD) begin
      if (m_turn) begin
        m_turn <= 1'b0;
        m_trdy <= 1'b0;
      end else if (!bus.irdy && !m_trdy) begin
        m_rp <= (m_rp + 1) % DEPTH;
        if ((m_rp + 1) % DEPTH == 0) m_trdy <= 1'b1;
      end else if (m_trdy) begin
        m_trdy <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic exp_oe;
  assign exp_oe = (m_mode == M_RD) && !m_trdy && !m_turn;

  always @(negedge clk) begin
    chk("cyc_trdy", {31'd0, bus.trdy}, {31'd0, m_trdy});
    chk("cyc_ad_oe", {31'd0, dut.ad_oe}, {31'd0, exp_oe});
    if (exp_oe) chk("cyc_ad_data", ad, m_mem[m_rp]);
  end

  task automatic cyc(input logic f, input logic [3:0] c, input logic i,
                     input logic drv, input logic [31:0] d);
    bus.frame = f;
    bus.cbe   = c;
    bus.irdy  = i;
    tb_oe     = drv;
    tb_ad     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic lit_trdy(input string name, input logic exp);
    chk(name, {31'd0, bus.trdy}, {31'd0, exp});
  endtask

  task automatic lit_rd(input string name, input logic [31:0] exp);
    chk(name, ad, exp);
    chk({name, "_oe"}, {31'd0, dut.ad_oe}, 32'd1);
  endtask

  task automatic lit_z(input string name);
    chk(name, {31'd0, dut.ad_oe}, 32'd0);
  endtask

  initial begin
    bus.frame = 1'b1;
    bus.cbe   = 4'h0;
    bus.irdy  = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lit_trdy("reset_trdy", 1'b1);
    lit_z("reset_ad_z");
    rst_n = 1'b1;
    cyc(1, 4'h0, 1, 0, 0);
    cyc(1, 4'h0, 1, 0, 0);
    lit_trdy("idle_trdy", 1'b1);

    // Write burst with an initiator wait after the second word
    cyc(0, 4'b0111, 1, 1, 287);
    lit_trdy("wr_start", 1'b0);
    cyc(0, 4'h0, 0, 1, 1000);
    cyc(0, 4'h0, 0, 1, 133);
    cyc(0, 4'h0, 1, 1, 133);
    lit_trdy("wr_irdy_wait", 1'b0);
    cyc(0, 4'h0, 0, 1, 176);
    cyc(0, 4'h0, 0, 1, 32'hAA);
    lit_trdy("wr_pause1", 1'b1);
    cyc(0, 4'h0, 0, 1, 32'hAA);
    lit_trdy("wr_resume1", 1'b0);
    chk("model_mem0", m_mem[0], 1000);
    chk("model_mem1", m_mem[1], 133);
    chk("model_mem2", m_mem[2], 176);
    chk("model_mem3", m_mem[3], 32'hAA);

    // Wrap-around overwrite
    cyc(0, 4'h0, 0, 1, 32'hBB);
    cyc(0, 4'h0, 0, 1, 32'hCC);
    cyc(0, 4'h0, 0, 1, 32'hDD);
    cyc(0, 4'h0, 0, 1, 32'hEE);
    lit_trdy("wr_pause2", 1'b1);
    cyc(0, 4'h0, 0, 1, 32'hEE);
    lit_trdy("wr_resume2", 1'b0);
    chk("model_wrap0", m_mem[0], 32'hBB);
    chk("model_wrap3", m_mem[3], 32'hEE);
    cyc(1, 4'h0, 1, 0, 0);
    lit_trdy("wr_term", 1'b1);

    // Read burst
    cyc(0, 4'b0110, 1, 1, 287);
    lit_trdy("rd_turn_trdy", 1'b1);
    lit_z("rd_turn_z");
    cyc(0, 4'h0, 0, 0, 0);
    lit_rd("rd_w0", 32'hBB);
    cyc(0, 4'h0, 0, 0, 0);
    lit_rd("rd_w1", 32'hCC);
    cyc(0, 4'h0, 0, 0, 0);
    lit_rd("rd_w2", 32'hDD);
    cyc(0, 4'h0, 0, 0, 0);
    lit_rd("rd_w3", 32'hEE);
    cyc(0, 4'h0, 0, 0, 0);
    lit_trdy("rd_pause", 1'b1);
    lit_z("rd_pause_z");
    cyc(0, 4'h0, 0, 0, 0);
    lit_rd("rd_wrap", 32'hBB);
    cyc(0, 4'h0, 1, 0, 0);
    lit_rd("rd_irdy_hold", 32'hBB);
    cyc(0, 4'h0, 0, 0, 0);
    lit_rd("rd_after_hold", 32'hCC);
    cyc(1, 4'h0, 1, 0, 0);
    lit_trdy("rd_term", 1'b1);
    lit_z("rd_term_z");

    // Unsupported command leaves the buffer alone
    cyc(0, 4'b0010, 1, 1, 287);
    lit_trdy("ign_trdy", 1'b1);
    cyc(0, 4'h0, 0, 1, 32'h1234);
    lit_trdy("ign_data_trdy", 1'b1);
    lit_z("ign_z");
    cyc(1, 4'h0, 1, 0, 0);
    cyc(0, 4'b0110, 1, 1, 0);
    cyc(0, 4'h0, 0, 0, 0);
    lit_rd("ign_unchanged", 32'hBB);
    cyc(1, 4'h0, 1, 0, 0);

    // Asynchronous reset in the middle of a write burst
    cyc(0, 4'b0111, 1, 1, 5);
    cyc(0, 4'h0, 0, 1, 32'h55);
    #2 rst_n = 1'b0;
    #1;
    lit_trdy("rst_async_trdy", 1'b1);
    lit_z("rst_async_z");
    bus.frame = 1'b1;
    bus.irdy  = 1'b1;
    tb_oe     = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 4'b0110, 1, 1, 0);
    cyc(0, 4'h0, 0, 0, 0);
    lit_rd("rst_clr_w0", 32'h0);
    cyc(0, 4'h0, 0, 0, 0);
    lit_rd("rst_clr_w1", 32'h0);
    chk("model_rst_mem3", m_mem[3], 32'h0);
    cyc(1, 4'h0, 1, 0, 0);
    cyc(1, 4'h0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
